// File: rtl/fixed_to_float_pipe_if.sv
// -----------------------------------------------------------------------------
// fixed_to_float_pipe_if
//
// Purpose : groups the input and output valid/ready channels of
//           fixed_to_float_pipe into one bundle. Member names keep the
//           converter's own port names, so the _i/_o suffixes are seen from
//           the converter's side.
//
// Parameters:
//   IN_W         width of the fixed-point sample; must match the converter
//
// Members (direction as seen by the converter):
//   in_valid_i   in   1      input sample valid
//   in_ready_o   out  1      converter accepts input this cycle
//   fixed_i      in   IN_W   fixed-point sample
//   out_valid_o  out  1      float_o valid
//   out_ready_i  in   1      downstream accepts output
//   float_o      out  32     IEEE 754 single-precision result
//   inexact_o    out  1      result lost nonzero low-order bits
//
// Modports:
//   slave  : the converter
//   master : the environment that feeds the converter and drains its output
// -----------------------------------------------------------------------------
interface fixed_to_float_pipe_if #(
    parameter int IN_W = 12
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [IN_W-1:0] fixed_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [31:0]     float_o;
    logic            inexact_o;

    modport slave (
        input  in_valid_i, fixed_i, out_ready_i,
        output in_ready_o, out_valid_o, float_o, inexact_o
    );

    modport master (
        output in_valid_i, fixed_i, out_ready_i,
        input  in_ready_o, out_valid_o, float_o, inexact_o
    );
endinterface

// File: rtl/fixed_to_float_pipe.sv
// -----------------------------------------------------------------------------
// fixed_to_float_pipe
//
// Purpose : converts one IN_W-bit fixed-point sample per cycle (value =
//           fixed_i * 2^-FRAC_W, unsigned or two's complement) into an IEEE 754
//           single-precision number through a 2-stage valid/ready pipeline
//           with a single global stall.
//
// Parameters:
//   IN_W    input width, 2..32
//   FRAC_W  fractional bits of the input, 0..IN_W
//   SIGNED  1 = two's-complement input, 0 = unsigned
//
// Ports:
//   clk_i   in  1  clock, rising edge
//   rst_ni  in  1  asynchronous active-low reset
//   bus     slave modport of fixed_to_float_pipe_if (handshakes, sample,
//           float_o result, inexact_o flag)
//
// Build option:
//   FX2FP_ROUND_EN  defined   : discarded fraction bits are rounded to
//                               nearest, ties to even
//                   undefined : discarded bits are truncated (toward zero)
//   Only visible when the fraction is wider than 23 bits (IN_W > 24).
//
// Stage 1 captures sign, magnitude, leading-zero count and a zero flag.
// Stage 2 normalises, builds exponent/mantissa and loads the output register.
// -----------------------------------------------------------------------------
module fixed_to_float_pipe #(
    parameter int IN_W   = 12,
    parameter int FRAC_W = 0,
    parameter bit SIGNED = 1'b0
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    fixed_to_float_pipe_if.slave bus
);
    localparam int         LZ_W     = $clog2(IN_W);
    localparam int         FW       = IN_W - 1;   // fraction bits after the hidden 1
    localparam logic [8:0] EXP_BASE = 9'(127 + IN_W - 1 - FRAC_W);

    // -------------------------------------------------------------------------
    // Global stall: the only place backpressure enters the pipe. Every stage
    // holds together, so no skid buffer is needed and order is trivially kept.
    // -------------------------------------------------------------------------
    logic stall;
    logic take;

    assign stall          = bus.out_valid_o & ~bus.out_ready_i;
    assign bus.in_ready_o = ~stall;
    assign take           = bus.in_valid_i & ~stall;

    // -------------------------------------------------------------------------
    // Stage 1: sign, magnitude, leading-zero count, zero flag
    // -------------------------------------------------------------------------
    logic            s1_valid_q;
    logic            s1_sign_d,  s1_sign_q;
    logic [IN_W-1:0] s1_mag_d,   s1_mag_q;
    logic [LZ_W-1:0] s1_lz_d,    s1_lz_q;
    logic            s1_zero_d,  s1_zero_q;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        s1_sign_d = SIGNED && bus.fixed_i[IN_W-1];
        // The most-negative input negates to 2^(IN_W-1), which still fits in
        // IN_W unsigned bits.
        s1_mag_d  = s1_sign_d ? (~bus.fixed_i + IN_W'(1)) : bus.fixed_i;
        s1_zero_d = (s1_mag_d == '0);
        // Ascending scan: the highest set bit is the last one to write lz.
        s1_lz_d   = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_mag_d[i]) begin
                s1_lz_d = LZ_W'(IN_W - 1 - i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= bus.in_valid_i;
        end
    end

    // NOTE: payload registers carry no reset; they are only ever read while
    // the matching valid bit is set, and that bit is reset.
    always_ff @(posedge clk_i) begin
        if (take) begin
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s1_lz_q   <= s1_lz_d;
            s1_zero_q <= s1_zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: normalise and pack
    // -------------------------------------------------------------------------
    logic [FW-1:0] frac;      // normalised magnitude without the hidden 1
    logic [63:0]   frac_al;   // fraction left-aligned at bit 63
    logic [22:0]   mant;
    logic [8:0]    exp9;
    logic          lost;
    logic [31:0]   float_d;
    logic          inexact_d;
`ifdef FX2FP_ROUND_EN
    logic          round_up;
    logic [23:0]   mant_r;
`endif

    always_comb begin
        frac            = FW'(s1_mag_q << s1_lz_q);
        frac_al         = '0;
        frac_al[63-:FW] = frac;
        // Bits 63:41 become the mantissa; anything in 40:0 is lost precision,
        // which can only happen when the fraction exceeds 23 bits.
        mant            = frac_al[63:41];
        lost            = |frac_al[40:0];
        exp9            = EXP_BASE - 9'(s1_lz_q);
`ifdef FX2FP_ROUND_EN
        // Round to nearest even: guard bit 40, sticky bits 39:0.
        round_up        = frac_al[40] & ((|frac_al[39:0]) | mant[0]);
        mant_r          = {1'b0, mant} + 24'(round_up);
        // Carry out of the mantissa: 1.111..1 rounds to 10.000..0.
        if (mant_r[23]) begin
            exp9 = exp9 + 9'd1;
        end
        mant            = mant_r[22:0];
`endif
        if (s1_zero_q) begin
            float_d   = 32'h0000_0000;   // +0 even in signed mode
            inexact_d = 1'b0;
        end else begin
            float_d   = {s1_sign_q, 8'(exp9), mant};
            inexact_d = lost;
        end
    end

    logic        out_valid_q;
    logic [31:0] float_q;
    logic        inexact_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            float_q     <= 32'h0000_0000;
            inexact_q   <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                float_q   <= float_d;
                inexact_q <= inexact_d;
            end
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.float_o     = float_q;
    assign bus.inexact_o   = inexact_q;

endmodule
